sixteen_bit_down_counter: RTL and testbench
===========================================

Name: sixteen_bit_down_counter

Overview:
- Loadable 16-bit countdown timer; the decrementing counterpart of the team's 16-bit incrementer.
- Next-value logic is a ripple chain of half-subtractors (diff = a XOR bin, bout = NOT a AND bin, bin[0] = 1). It is built from the same NAND-level gate library.
- The chain feeds a registered count plus a 3-state control FSM with a one-cycle done pulse.
- Used as a programmable delay or terminal-count generator beside the incrementer-based up counters.

Parameters:
- WIDTH, 16, counter and load-data width (all checks run at 16).
- WRAP, 0, 0 = stop at zero in DONE; 1 = free-run with wrap 0 -> all-ones.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load  input  1  synchronous load of d into q.
- d  input  WIDTH  load value.
- start  input  1  begin counting (IDLE only).
- stop  input  1  abort counting (RUN only); q is held.
- en  input  1  count-enable tick; one decrement per clk edge with en=1 in RUN.
- q  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches zero.
- b  output  1  one-cycle borrow pulse on wrap 0 -> all-ones (WRAP=1 only).

Behaviour:
- Reset (async, any time, including mid-count):
  - q = 0, state = IDLE, busy = 0, done = 0, b = 0.
  - First active edge after reset deasserts is evaluated normally.
- Decrement path:
  - Combinational dec = q - 1 mod 2^WIDTH, via the ripple half-subtractor chain.
  - Final borrow-out = 1 iff q == 0.
  - Must be bit-exact versus arithmetic subtraction for all 65536 inputs.
- All outputs are registered; done and b assert in the same cycle q shows the new value.
- Priority in every state: reset > load > stop > start > en.
- IDLE:
  - load=1, start=0: q <= d; stay IDLE.
  - load=1, start=1: q <= d. If d != 0, go to RUN; if d == 0, go to DONE with done=1.
  - start=1, load=0: if q != 0, go to RUN; if q == 0, go to DONE with done=1.
  - en ignored; q holds.
- RUN (busy=1):
  - load=1: q <= d; stay RUN. If d == 0 and WRAP=0, go to DONE with done=1.
  - stop=1: go to IDLE; q holds; done not asserted.
  - en=1, q > 1: q <= dec.
  - en=1, q == 1: q <= 0 and done=1. WRAP=0: go to DONE. WRAP=1: stay RUN.
  - en=1, q == 0 (WRAP=1 only): q <= all-ones, b=1; stay RUN.
  - en=0: q holds; no pulses.
  - start ignored.
- DONE (WRAP=0 only):
  - q held at 0; busy=0.
  - en, start and stop ignored; done does not re-pulse.
  - load=1: q <= d, go to IDLE. A start in the same cycle is ignored, so a restart requires a later start.
- done and b:
  - Never high for more than one consecutive cycle unless re-triggered by a new qualifying event.
  - With WRAP=0, b is constant 0.
- Underflow never occurs with WRAP=0; q never becomes all-ones except by load.

Test Plan:
- Reset mid-count: load 0x0005, start, 2 en ticks (q=0x0003), assert reset between edges -> q=0, busy=0, done=0 immediately and asynchronously, state IDLE.
- Basic countdown, WRAP=0: load+start with d=0x0003, en held high -> q goes 3,2,1,0 on successive edges. done=1 only in the cycle q becomes 0, busy drops the same cycle, and q stays 0 for 10 further en cycles.
- Gated enable and stop: d=0x0100, start, en toggled 1/0 for 8 cycles -> q=0x00FC. Then stop -> IDLE with q=0x00FC. A later start resumes down from 0x00FC.
- Zero load: load+start with d=0x0000 -> DONE next edge, done=1 for exactly one cycle, busy never high.
- WRAP=1 boundary: d=0x0001, start, en high -> q=0 with done=1, next edge q=0xFFFF with b=1, next edge q=0xFFFE with b=0, busy stays 1.
- Load during RUN and carry chain: in RUN with q=0x8000, load d=0x1000 with en=1 (load wins) -> q=0x1000. Then one en -> q=0x0FFF, exercising a borrow ripple through 12 bits. Exhaustive check of the dec path against q-1.

Source files
------------

// File: rtl/sixteen_bit_down_counter.sv
// Loadable countdown timer: ripple half-subtractor decrement, 3-state control FSM, done/borrow pulses.
// Latency: one clk edge from load/start/en to q, busy, done and b (all registered).
// Backpressure: none; en is a per-edge count tick, and load/stop/start are taken whenever they are asserted.

// Ripple chain of half-subtractors computing a - 1 (borrow-in of stage 0 tied high).
module sixteen_bit_down_counter_dec #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  logic [WIDTH:0] bin;

  assign bin[0] = 1'b1;

  // Each stage: diff = a ^ bin, borrow-out = ~a & bin; the borrow ripples up through trailing zeros.
  for (genvar i = 0; i < WIDTH; i++) begin : g_hs
    assign diff[i]  = a[i] ^ bin[i];
    assign bin[i+1] = ~a[i] & bin[i];
  end

  // Final borrow is high only when every bit of a was zero.
  assign bout = bin[WIDTH];

endmodule

// Countdown timer top: count register, control FSM and registered done/borrow pulses.
module sixteen_bit_down_counter #(
  parameter int WIDTH = 16,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             b
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic             WRAP_ON = (WRAP != 0);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             b_nxt;
  logic [WIDTH-1:0] dec;
  logic             dec_bout;

  sixteen_bit_down_counter_dec #(.WIDTH(WIDTH)) u_dec (
    .a    (q),
    .diff (dec),
    .bout (dec_bout)
  );

  // State, count and pulse registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      q     <= '0;
      done  <= 1'b0;
      b     <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
      b     <= b_nxt;
    end
  end

  // Next-state and next-count decode; priority load > stop > start > en.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    done_nxt  = 1'b0;
    b_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          q_nxt = d;
          if (start) begin
            // A zero start value terminates at once; in free-run mode there is no DONE state.
            done_nxt  = (d == '0);
            state_nxt = ((d != '0) || WRAP_ON) ? ST_RUN : ST_DONE;
          end
        end else if (start) begin
          done_nxt  = (q == '0);
          state_nxt = ((q != '0) || WRAP_ON) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (load) begin
          q_nxt = d;
          if ((d == '0) && !WRAP_ON) begin
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
        end else if (stop) begin
          state_nxt = ST_IDLE;
        end else if (en) begin
          if (q == ONE) begin
            q_nxt    = dec;
            done_nxt = 1'b1;
            if (!WRAP_ON) state_nxt = ST_DONE;
          end else if (dec_bout) begin
            // Zero in RUN only happens in free-run mode; the stop-at-zero build parks in DONE instead.
            if (WRAP_ON) begin
              q_nxt = dec;
              b_nxt = 1'b1;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            q_nxt = dec;
          end
        end
      end
      ST_DONE: begin
        if (load) begin
          q_nxt     = d;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_sixteen_bit_down_counter.sv
// Bench for the countdown timer: stop-at-zero and free-run builds side by side, plus the decrement chain.
// Latency: inputs change 1 time unit after a rising edge, outputs are sampled 1 time unit after the next.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_sixteen_bit_down_counter;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] d;
  logic        start;
  logic        stop;
  logic        en;
  logic [15:0] q0, q1;
  logic        busy0, busy1, done0, done1, b0, b1;
  logic [15:0] dec_a, dec_diff;
  logic        dec_bout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = stop-at-zero build, 1 = free-run build.
  int          m_st[2];
  logic [15:0] m_q[2];
  logic        m_done[2];
  logic        m_b[2];

  sixteen_bit_down_counter #(.WIDTH(16), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .d(d), .start(start), .stop(stop), .en(en),
    .q(q0), .busy(busy0), .done(done0), .b(b0)
  );

  sixteen_bit_down_counter #(.WIDTH(16), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .d(d), .start(start), .stop(stop), .en(en),
    .q(q1), .busy(busy1), .done(done1), .b(b1)
  );

  sixteen_bit_down_counter_dec #(.WIDTH(16)) u_dec (
    .a(dec_a), .diff(dec_diff), .bout(dec_bout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_st[w] = M_IDLE; m_q[w] = 16'h0; m_done[w] = 1'b0; m_b[w] = 1'b0;
    end
  endtask

  // Next state from the behavioural rules, using plain arithmetic for the decrement.
  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      logic wrap;
      logic nd, nb;
      wrap = (w == 1);
      nd = 1'b0;
      nb = 1'b0;
      if (reset) begin
        m_st[w] = M_IDLE; m_q[w] = 16'h0;
      end else begin
        case (m_st[w])
          M_IDLE: begin
            if (load) begin
              m_q[w] = d;
              if (start) begin
                nd = (d == 16'h0);
                m_st[w] = (d != 16'h0 || wrap) ? M_RUN : M_DONE;
              end
            end else if (start) begin
              nd = (m_q[w] == 16'h0);
              m_st[w] = (m_q[w] != 16'h0 || wrap) ? M_RUN : M_DONE;
            end
          end
          M_RUN: begin
            if (load) begin
              m_q[w] = d;
              if (d == 16'h0 && !wrap) begin nd = 1'b1; m_st[w] = M_DONE; end
            end else if (stop) begin
              m_st[w] = M_IDLE;
            end else if (en) begin
              if (m_q[w] == 16'h1) begin
                m_q[w] = 16'h0; nd = 1'b1;
                if (!wrap) m_st[w] = M_DONE;
              end else if (m_q[w] == 16'h0) begin
                if (wrap) begin m_q[w] = 16'hFFFF; nb = 1'b1; end
                else m_st[w] = M_DONE;
              end else begin
                m_q[w] = 16'((32'(m_q[w]) + 32'hFFFF) % 32'h10000);
              end
            end
          end
          default: begin
            if (load) begin m_q[w] = d; m_st[w] = M_IDLE; end
          end
        endcase
      end
      m_done[w] = nd;
      m_b[w]    = nb;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    check("q0",    32'(q0),    32'(m_q[0]));
    check("busy0", 32'(busy0), 32'(m_st[0] == M_RUN));
    check("done0", 32'(done0), 32'(m_done[0]));
    check("b0",    32'(b0),    32'(m_b[0]));
    check("q1",    32'(q1),    32'(m_q[1]));
    check("busy1", 32'(busy1), 32'(m_st[1] == M_RUN));
    check("done1", 32'(done1), 32'(m_done[1]));
    check("b1",    32'(b1),    32'(m_b[1]));
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; d = 16'h0;
  endtask

  initial begin
    reset = 1'b1;
    dec_a = 16'h0;
    idle_inputs();
    model_reset();
    #2;
    check("rst_q", 32'(q0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_b1", 32'(b1), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset in the middle of a count.
    load = 1'b1; d = 16'h0005; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0; en = 1'b1;
    tick();
    tick();
    check("mid_q", 32'(q0), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_q", 32'(q0), 32'h0);
    check("arst_busy", 32'(busy0), 32'h0);
    check("arst_done", 32'(done0), 32'h0);
    check("arst_q1", 32'(q1), 32'h0);
    model_reset();
    #1;
    reset = 1'b0;
    tick();
    check_all();

    // Basic countdown 3,2,1,0 with en held high.
    load = 1'b1; d = 16'h0003; start = 1'b1; en = 1'b1;
    tick();
    check("cd_q3", 32'(q0), 32'h3);
    check("cd_busy", 32'(busy0), 32'h1);
    load = 1'b0; start = 1'b0;
    tick();
    check("cd_q2", 32'(q0), 32'h2);
    tick();
    check("cd_q1", 32'(q0), 32'h1);
    check("cd_done_early", 32'(done0), 32'h0);
    tick();
    check("cd_q0", 32'(q0), 32'h0);
    check("cd_done", 32'(done0), 32'h1);
    check("cd_busy_drop", 32'(busy0), 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cd_hold_q", 32'(q0), 32'h0);
      check("cd_hold_done", 32'(done0), 32'h0);
      check_all();
    end

    // Gated enable, stop and resume from 0x0100.
    en = 1'b0; load = 1'b1; d = 16'h0100;
    tick();
    load = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    tick();
    check("ge_busy", 32'(busy0), 32'h1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      tick();
    end
    check("ge_q", 32'(q0), 32'h00FC);
    en = 1'b0; stop = 1'b1;
    tick();
    check("stop_busy", 32'(busy0), 32'h0);
    check("stop_q", 32'(q0), 32'h00FC);
    check("stop_done", 32'(done0), 32'h0);
    stop = 1'b0; start = 1'b1; en = 1'b1;
    tick();
    check("resume_busy", 32'(busy0), 32'h1);
    check("resume_q", 32'(q0), 32'h00FC);
    start = 1'b0;
    tick();
    check("resume_dec", 32'(q0), 32'h00FB);
    check_all();

    // Zero load with start goes straight to DONE.
    en = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; load = 1'b1; d = 16'h0; start = 1'b1;
    tick();
    check("zl_done", 32'(done0), 32'h1);
    check("zl_busy", 32'(busy0), 32'h0);
    load = 1'b0; start = 1'b0;
    tick();
    check("zl_done_once", 32'(done0), 32'h0);
    check("zl_busy2", 32'(busy0), 32'h0);
    check_all();

    // Free-run wrap through zero to all-ones.
    load = 1'b1; d = 16'h0001; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0; en = 1'b1;
    tick();
    check("wr_q0", 32'(q1), 32'h0);
    check("wr_done", 32'(done1), 32'h1);
    check("wr_b_low", 32'(b1), 32'h0);
    tick();
    check("wr_qffff", 32'(q1), 32'hFFFF);
    check("wr_b", 32'(b1), 32'h1);
    check("wr_done_low", 32'(done1), 32'h0);
    tick();
    check("wr_qfffe", 32'(q1), 32'hFFFE);
    check("wr_b_once", 32'(b1), 32'h0);
    check("wr_busy", 32'(busy1), 32'h1);
    check("nowrap_b", 32'(b0), 32'h0);
    check_all();

    // Load wins over en during RUN, then a 12-bit borrow ripple.
    en = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0; load = 1'b1; d = 16'h8000; start = 1'b1;
    tick();
    start = 1'b0; d = 16'h1000; en = 1'b1;
    tick();
    check("ld_run_q", 32'(q0), 32'h1000);
    load = 1'b0;
    tick();
    check("ripple_q", 32'(q0), 32'h0FFF);
    check("ripple_q1", 32'(q1), 32'h0FFF);
    check_all();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset = ($urandom_range(0, 199) == 0);
      load  = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 6) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r == 0)      d = 16'h0;
      else if (r < 8)  d = 16'($urandom_range(1, 24));
      else             d = 16'($urandom);
      tick();
      check_all();
    end
    reset = 1'b0;
    idle_inputs();

    // Exhaustive decrement chain versus arithmetic q - 1.
    for (int i = 0; i < 65536; i++) begin
      dec_a = 16'(i);
      #1;
      check("dec", {15'h0, dec_bout, dec_diff}, {15'h0, (i == 0), 16'((i + 65535) % 65536)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
